// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: byte-enabled word memory with valid/ready request/response channels and a configurable read pipeline
module data_memory_pipelined #(
    parameter int    ADDR_BITS    = 16,
    parameter int    WORD_BYTES   = 4,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_HEX     = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_BITS-1:0]    req_address,
    input  logic [WORD_BYTES-1:0]   req_byteena,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic                    resp_error,
    output logic [8*WORD_BYTES-1:0] resp_rdata
);
    localparam int DW = 8*WORD_BYTES;
    localparam logic [ADDR_BITS-1:0] OFS_MASK = ADDR_BITS'(WORD_BYTES-1);

    typedef struct packed {
        logic          valid;
        logic          write;
        logic          error;
        logic [DW-1:0] data;
    } stage_t;

    logic [7:0]           mem [2**ADDR_BITS];
    stage_t               stage_q [READ_LATENCY];
    stage_t               stage_d [READ_LATENCY];
    stage_t               incoming;
    logic                 stall;
    logic                 accept;
    logic                 misaligned;
    logic [ADDR_BITS-1:0] base;
    logic [DW-1:0]        rd_word;

    // Handshake, alignment and the word stored at the request address before this edge's write
    always_comb begin
        stall = stage_q[READ_LATENCY-1].valid && !resp_ready;
        req_ready = !stall;
        accept = req_valid && req_ready && !reset;
        misaligned = (req_address & OFS_MASK) != '0;
        base = req_address & ~OFS_MASK;
        rd_word = '0;
        for (int i = 0; i < WORD_BYTES; i++) rd_word[8*i +: 8] = mem[base + ADDR_BITS'(i)];
        incoming = accept ? '{valid: 1'b1, write: req_write, error: misaligned,
                              data: (req_write || misaligned) ? '0 : rd_word} : '0;
    end

    // The whole pipeline moves together; a stalled output freezes every stage so bubbles are kept
    always_comb begin
        stage_d[0] = stall ? stage_q[0] : incoming;
        for (int s = 1; s < READ_LATENCY; s++) stage_d[s] = stall ? stage_q[s] : stage_q[s-1];
    end

    // Stage registers; reset discards everything still in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < READ_LATENCY; s++) stage_q[s] <= '0;
        end else begin
            for (int s = 0; s < READ_LATENCY; s++) stage_q[s] <= stage_d[s];
        end
    end

    // Byte-enabled commit to storage; misaligned writes leave memory untouched
    always_ff @(posedge clock) begin
        if (accept && req_write && !misaligned) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (req_byteena[i]) mem[base + ADDR_BITS'(i)] <= req_wdata[8*i +: 8];
            end
        end
    end

    assign resp_valid = stage_q[READ_LATENCY-1].valid;
    assign resp_write = stage_q[READ_LATENCY-1].write;
    assign resp_error = stage_q[READ_LATENCY-1].error;
    assign resp_rdata = stage_q[READ_LATENCY-1].data;
endmodule

// File: tb/tb_data_memory_pipelined.sv
// tb_data_memory_pipelined: directed tests against a queue-based reference model of the pipelined data memory
module tb_data_memory_pipelined;
    localparam int AB  = 16;
    localparam int WB  = 4;
    localparam int LAT = 3;

    logic          clock = 0;
    logic          reset = 1;
    logic          req_valid = 0;
    logic          req_ready;
    logic          req_write = 0;
    logic [AB-1:0] req_address = '0;
    logic [WB-1:0] req_byteena = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1;
    logic          resp_write;
    logic          resp_error;
    logic [31:0]   resp_rdata;

    data_memory_pipelined #(
        .ADDR_BITS(AB), .WORD_BYTES(WB), .READ_LATENCY(LAT), .INIT_HEX("")
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_byteena(req_byteena), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_error(resp_error), .resp_rdata(resp_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        write;
        logic        error;
        logic [31:0] data;
        int          age;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        write;
        logic        error;
        logic [31:0] data;
    } obs_t;

    exp_t        q[$];
    obs_t        obs[$];
    logic [7:0]  ref_mem [2**AB];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        m_ev, m_stall, m_mis, e_valid;
    logic [31:0] m_word;
    int          m_base;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge counter used to time-stamp acceptances and consumed responses
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: in-order response queue, each entry ageing by one per non-stalled edge
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            m_ev = q.size() > 0 && q[0].age == LAT;
            m_stall = m_ev && !resp_ready;
            if (m_ev && resp_ready) void'(q.pop_front());
            if (!m_stall) for (int k = 0; k < q.size(); k++) q[k].age = q[k].age + 1;
            if (req_valid && !m_stall) begin
                m_mis = (int'(req_address) % WB) != 0;
                m_base = int'(req_address) - (int'(req_address) % WB);
                for (int i = 0; i < WB; i++) m_word[8*i +: 8] = ref_mem[m_base + i];
                if (req_write && !m_mis)
                    for (int i = 0; i < WB; i++) if (req_byteena[i]) ref_mem[m_base + i] = req_wdata[8*i +: 8];
                q.push_back('{write: req_write, error: m_mis, data: (req_write || m_mis) ? 32'h0 : m_word, age: 1});
            end
        end
    end

    // Per-cycle comparison against the model, and a log of every consumed response
    always @(negedge clock) begin
        if (!reset) begin
            e_valid = q.size() > 0 && q[0].age == LAT;
            chk("resp_valid", resp_valid, e_valid);
            chk("req_ready", req_ready, !(e_valid && !resp_ready));
            if (e_valid) begin
                chk("resp_write", resp_write, q[0].write);
                chk("resp_error", resp_error, q[0].error);
                chk("resp_rdata", resp_rdata, q[0].data);
            end
            if (resp_valid && resp_ready) obs.push_back('{cyc: cyc + 1, write: resp_write, error: resp_error, data: resp_rdata});
        end
    end

    task automatic issue(input logic w, input logic [AB-1:0] a, input logic [WB-1:0] be,
                         input logic [31:0] d, output int acc);
        int   n = 0;
        logic ok;
        req_valid = 1; req_write = w; req_address = a; req_byteena = be; req_wdata = d;
        do begin
            @(negedge clock);
            ok = req_ready;
            @(posedge clock);
            n++;
        end while (!ok && n < 50);
        #1;
        acc = cyc;
        chk("issue accepted", ok, 1'b1);
    endtask

    task automatic idle_wait(input int n);
        req_valid = 0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, a8, n0, n;
        logic [31:0] held;
        // Reset with a request presented: nothing must come of it
        req_valid = 1; req_write = 1; req_address = 16'h0040; req_byteena = 4'hF; req_wdata = 32'h1111_1111;
        repeat (3) @(posedge clock);
        #2;
        chk("reset resp_valid", resp_valid, 1'b0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        reset = 0;
        req_valid = 0;
        @(negedge clock);
        chk("post-reset req_ready", req_ready, 1'b1);
        chk("post-reset resp_valid", resp_valid, 1'b0);
        idle_wait(6);
        chk("no response for reset-time request", obs.size(), 0);

        // Byte-enable write then readback
        n0 = obs.size();
        issue(1, 16'h0010, 4'b1111, 32'hDEAD_BEEF, a);
        issue(1, 16'h0010, 4'b0010, 32'h0000_1200, a);
        issue(0, 16'h0010, 4'b0000, 32'h0, a);
        idle_wait(LAT + 3);
        chk("t2 count", obs.size() - n0, 3);
        chk("t2 rdata", obs[n0+2].data, 32'hDEAD_12EF);
        chk("t2 error", obs[n0+2].error, 1'b0);
        chk("t2 latency", obs[n0+2].cyc - a, LAT);

        // Write followed immediately by read, then 8 back-to-back reads
        n0 = obs.size();
        issue(1, 16'h0020, 4'hF, 32'hCAFE_F00D, a);
        issue(0, 16'h0020, 4'h0, 32'h0, a);
        for (int i = 1; i < 8; i++) issue(1, 16'(16'h0020 + 4*i), 4'hF, 32'hA5A5_0000 + i, a);
        for (int i = 0; i < 8; i++) begin
            issue(0, 16'(16'h0020 + 4*i), 4'h0, 32'h0, a);
            if (i == 0) a8 = a;
        end
        idle_wait(LAT + 3);
        chk("t3 count", obs.size() - n0, 17);
        chk("t3 read after write", obs[n0+1].data, 32'hCAFE_F00D);
        for (int k = 0; k < 8; k++) begin
            chk("t3 burst cycle", obs[n0+9+k].cyc, a8 + LAT + k);
            chk("t3 burst data", obs[n0+9+k].data, k == 0 ? 32'hCAFE_F00D : 32'hA5A5_0000 + k);
        end

        // Backpressure with two reads in flight
        n0 = obs.size();
        resp_ready = 0;
        issue(0, 16'h0010, 4'h0, 32'h0, a);
        issue(0, 16'h0020, 4'h0, 32'h0, a);
        req_valid = 0;
        n = 0;
        do begin @(negedge clock); n++; end while (!resp_valid && n < 20);
        chk("t4 resp_valid under stall", resp_valid, 1'b1);
        held = resp_rdata;
        chk("t4 held data", held, 32'hDEAD_12EF);
        repeat (5) begin
            @(negedge clock);
            chk("t4 req_ready low", req_ready, 1'b0);
            chk("t4 rdata stable", resp_rdata, held);
        end
        @(posedge clock);
        #1;
        resp_ready = 1;
        idle_wait(LAT + 3);
        chk("t4 count", obs.size() - n0, 2);
        chk("t4 first", obs[n0].data, 32'hDEAD_12EF);
        chk("t4 second", obs[n0+1].data, 32'hCAFE_F00D);

        // Misaligned write and read
        n0 = obs.size();
        issue(1, 16'h0013, 4'hF, 32'hFFFF_FFFF, a);
        issue(0, 16'h0010, 4'h0, 32'h0, a);
        issue(0, 16'h0011, 4'h0, 32'h0, a);
        idle_wait(LAT + 3);
        chk("t5 count", obs.size() - n0, 3);
        chk("t5 wr error", obs[n0].error, 1'b1);
        chk("t5 wr write", obs[n0].write, 1'b1);
        chk("t5 wr rdata", obs[n0].data, 32'h0);
        chk("t5 aligned unchanged", obs[n0+1].data, 32'hDEAD_12EF);
        chk("t5 aligned error", obs[n0+1].error, 1'b0);
        chk("t5 misread rdata", obs[n0+2].data, 32'h0);
        chk("t5 misread error", obs[n0+2].error, 1'b1);
        chk("t5 misread write", obs[n0+2].write, 1'b0);

        // Reset pulse between edges with three reads in flight
        issue(1, 16'h0050, 4'hF, 32'h1234_5678, a);
        issue(0, 16'h0050, 4'h0, 32'h0, a);
        issue(0, 16'h0010, 4'h0, 32'h0, a);
        issue(0, 16'h0020, 4'h0, 32'h0, a);
        req_valid = 0;
        #1;
        chk("t6 valid before reset", resp_valid, 1'b1);
        reset = 1;
        #1;
        chk("t6 valid drops", resp_valid, 1'b0);
        chk("t6 rdata clears", resp_rdata, 32'h0);
        reset = 0;
        n0 = obs.size();
        idle_wait(8);
        chk("t6 no stale responses", obs.size() - n0, 0);
        issue(0, 16'h0050, 4'h0, 32'h0, a);
        idle_wait(LAT + 3);
        chk("t6 count", obs.size() - n0, 1);
        chk("t6 committed write", obs[n0].data, 32'h1234_5678);

        // Request held across an edge during reset must not write
        issue(1, 16'h0060, 4'hF, 32'h1122_3344, a);
        req_write = 1; req_address = 16'h0060; req_byteena = 4'hF; req_wdata = 32'hBAD0_BAD0;
        #2;
        reset = 1;
        @(posedge clock);
        #2;
        reset = 0;
        req_valid = 0;
        idle_wait(LAT + 3);
        n0 = obs.size();
        issue(0, 16'h0060, 4'h0, 32'h0, a);
        idle_wait(LAT + 3);
        chk("t7 count", obs.size() - n0, 1);
        chk("t7 reset-time write ignored", obs[n0].data, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
